// File: rtl/pkt_rx_router.sv
// -----------------------------------------------------------------------------
// pkt_rx_router
//
// Ingress packet receiver. Deserialises a byte stream of the form
//   src_id, dest_id, size, data[0 .. size-1], crc
// into a 16-byte buffer, validates it (crc = XOR of the data bytes, plus an
// optional source filter) and then writes the buffered data into one of three
// output-port FIFOs, selected by dest_id:
//   0..85 -> port 1, 86..170 -> port 2, 171..255 -> port 3.
// Packets that fail validation, that are too large (size > 15), or that are
// aborted (packet_valid_i dropping mid-packet) are discarded without any
// FIFO write.
//
// Configuration macro:
//   SRC_FILTER_EN  defined   : a packet is trusted only if src_id[7:4] == 0
//                             and the crc matches.
//                  undefined : only the crc check decides.
//
// Ports:
//   clk1               in   sole clock, rising edge
//   rst                in   asynchronous active-low reset
//   packet_valid_i     in   sender drives a valid byte on pdata
//   pdata[7:0]         in   packet byte, one per clock
//   wfull_port_1/2/3   in   full flag of each port FIFO
//   stop_packet_send   out  back-pressure, high exactly while flushing
//   winc_port_1/2/3    out  one-cycle FIFO write strobe
//   wdata_port_1/2/3   out  FIFO write data (0 when not writing)
//   waddr_in_port_1/2/3 out FIFO write address (0 when not writing)
// -----------------------------------------------------------------------------
module pkt_rx_router (
    input  logic       clk1,
    input  logic       rst,
    input  logic       packet_valid_i,
    input  logic [7:0] pdata,
    input  logic       wfull_port_1,
    input  logic       wfull_port_2,
    input  logic       wfull_port_3,
    output logic       stop_packet_send,
    output logic       winc_port_1,
    output logic       winc_port_2,
    output logic       winc_port_3,
    output logic [7:0] wdata_port_1,
    output logic [7:0] wdata_port_2,
    output logic [7:0] wdata_port_3,
    output logic [3:0] waddr_in_port_1,
    output logic [3:0] waddr_in_port_2,
    output logic [3:0] waddr_in_port_3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEST,
        S_SIZE,
        S_DATA,
        S_CRC,
        S_FLUSH,
        S_DISCARD
    } state_e;

    typedef enum logic [1:0] {
        PORT_1,
        PORT_2,
        PORT_3
    } port_e;

    state_e     state_q, state_d;
    port_e      port_q;
    logic       src_pass_q;      // source-filter verdict, taken when src_id arrives
    logic [7:0] size_q;
    logic [7:0] cnt_q;           // data byte counter (DATA) / byte counter (DISCARD)
    logic [7:0] xor_q;           // running XOR of the data bytes
    logic [3:0] flush_idx_q;     // next buffer byte to write out
    logic [7:0] buffer_q [16];
    logic [3:0] addr_1_q, addr_2_q, addr_3_q;

    logic src_pass;
    logic sel_full;
    logic trusted;
    logic data_last;
    logic flush_last;
    logic flush_write;
    logic wr_1, wr_2, wr_3;

    // Only the filter verdict is kept, not src_id itself: nothing else in the
    // design looks at the source id.
`ifdef SRC_FILTER_EN
    assign src_pass = (pdata[7:4] == 4'd0);
`else
    assign src_pass = 1'b1;
`endif

    function automatic port_e port_of(input logic [7:0] dest);
        port_e p;
        if (dest <= 8'd85)       p = PORT_1;
        else if (dest <= 8'd170) p = PORT_2;
        else                     p = PORT_3;
        return p;
    endfunction

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_full = 1'b0;
        case (port_q)
            PORT_1:  sel_full = wfull_port_1;
            PORT_2:  sel_full = wfull_port_2;
            PORT_3:  sel_full = wfull_port_3;
            default: sel_full = 1'b0;
        endcase
    end

    assign trusted     = (pdata == xor_q) && src_pass_q;
    assign data_last   = (cnt_q == size_q - 8'd1);
    assign flush_last  = ({4'd0, flush_idx_q} == size_q - 8'd1);
    assign flush_write = (state_q == S_FLUSH) && !sel_full;
    assign wr_1        = flush_write && (port_q == PORT_1);
    assign wr_2        = flush_write && (port_q == PORT_2);
    assign wr_3        = flush_write && (port_q == PORT_3);

    assign stop_packet_send = (state_q == S_FLUSH);

    // ------------------------------------------------------------------ FSM
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (packet_valid_i) state_d = S_DEST;
            end
            S_DEST: begin
                state_d = packet_valid_i ? S_SIZE : S_IDLE;
            end
            S_SIZE: begin
                if (!packet_valid_i)     state_d = S_IDLE;
                else if (pdata == 8'd0)  state_d = S_CRC;
                else if (pdata > 8'd15)  state_d = S_DISCARD;
                else                     state_d = S_DATA;
            end
            S_DATA: begin
                if (!packet_valid_i) state_d = S_IDLE;
                else if (data_last)  state_d = S_CRC;
            end
            S_CRC: begin
                // Size 0 passes the crc check but has nothing to write.
                if (packet_valid_i && trusted && (size_q != 8'd0)) state_d = S_FLUSH;
                else                                              state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (flush_write && flush_last) state_d = S_IDLE;
            end
            S_DISCARD: begin
                // cnt_q == size_q is the crc byte, the last one to swallow.
                if (cnt_q == size_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            port_q      <= PORT_1;
            src_pass_q  <= 1'b0;
            size_q      <= 8'd0;
            cnt_q       <= 8'd0;
            xor_q       <= 8'd0;
            flush_idx_q <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (packet_valid_i) src_pass_q <= src_pass;
                end
                S_DEST: begin
                    if (packet_valid_i) port_q <= port_of(pdata);
                end
                S_SIZE: begin
                    if (packet_valid_i) begin
                        size_q      <= pdata;
                        cnt_q       <= 8'd0;
                        xor_q       <= 8'd0;
                        flush_idx_q <= 4'd0;
                    end
                end
                S_DATA: begin
                    if (packet_valid_i) begin
                        cnt_q <= cnt_q + 8'd1;
                        xor_q <= xor_q ^ pdata;
                    end
                end
                S_DISCARD: begin
                    cnt_q <= cnt_q + 8'd1;
                end
                S_FLUSH: begin
                    if (flush_write) flush_idx_q <= flush_idx_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the packet buffer is deliberately not reset; it is always written
    // before it is read, and leaving it reset-free lets it map onto plain RAM.
    always_ff @(posedge clk1) begin
        if (state_q == S_DATA && packet_valid_i) buffer_q[cnt_q[3:0]] <= pdata;
    end

    // ------------------------------------------------------ FIFO write ports
    // Write outputs are registered and return to 0 whenever the port is not
    // being written, so unselected ports never show activity.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            winc_port_1     <= 1'b0;
            winc_port_2     <= 1'b0;
            winc_port_3     <= 1'b0;
            wdata_port_1    <= 8'd0;
            wdata_port_2    <= 8'd0;
            wdata_port_3    <= 8'd0;
            waddr_in_port_1 <= 4'd0;
            waddr_in_port_2 <= 4'd0;
            waddr_in_port_3 <= 4'd0;
            addr_1_q        <= 4'd0;
            addr_2_q        <= 4'd0;
            addr_3_q        <= 4'd0;
        end else begin
            winc_port_1     <= wr_1;
            winc_port_2     <= wr_2;
            winc_port_3     <= wr_3;
            wdata_port_1    <= wr_1 ? buffer_q[flush_idx_q] : 8'd0;
            wdata_port_2    <= wr_2 ? buffer_q[flush_idx_q] : 8'd0;
            wdata_port_3    <= wr_3 ? buffer_q[flush_idx_q] : 8'd0;
            waddr_in_port_1 <= wr_1 ? addr_1_q : 4'd0;
            waddr_in_port_2 <= wr_2 ? addr_2_q : 4'd0;
            waddr_in_port_3 <= wr_3 ? addr_3_q : 4'd0;
            // Address counters persist across packets and wrap 15 -> 0.
            if (wr_1) addr_1_q <= addr_1_q + 4'd1;
            if (wr_2) addr_2_q <= addr_2_q + 4'd1;
            if (wr_3) addr_3_q <= addr_3_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_pkt_rx_router.sv
// -----------------------------------------------------------------------------
// tb_pkt_rx_router
//
// Directed self-checking bench for pkt_rx_router. A negedge monitor records
// every FIFO write (data, address, cycle stamp) per port, counts cycles with
// stop_packet_send high, and counts stray nonzero wdata/waddr without winc.
// Expected data, addresses, timing and port selection are computed by hand
// in the stimulus and by a small per-port address model.
// -----------------------------------------------------------------------------
module tb_pkt_rx_router;

    logic       clk1 = 1'b0;
    logic       rst = 1'b0;
    logic       packet_valid_i = 1'b0;
    logic [7:0] pdata = 8'd0;
    logic       wfull_port_1 = 1'b0;
    logic       wfull_port_2 = 1'b0;
    logic       wfull_port_3 = 1'b0;
    logic       stop_packet_send;
    logic       winc_port_1, winc_port_2, winc_port_3;
    logic [7:0] wdata_port_1, wdata_port_2, wdata_port_3;
    logic [3:0] waddr_in_port_1, waddr_in_port_2, waddr_in_port_3;

    pkt_rx_router dut (
        .clk1            (clk1),
        .rst             (rst),
        .packet_valid_i  (packet_valid_i),
        .pdata           (pdata),
        .wfull_port_1    (wfull_port_1),
        .wfull_port_2    (wfull_port_2),
        .wfull_port_3    (wfull_port_3),
        .stop_packet_send(stop_packet_send),
        .winc_port_1     (winc_port_1),
        .winc_port_2     (winc_port_2),
        .winc_port_3     (winc_port_3),
        .wdata_port_1    (wdata_port_1),
        .wdata_port_2    (wdata_port_2),
        .wdata_port_3    (wdata_port_3),
        .waddr_in_port_1 (waddr_in_port_1),
        .waddr_in_port_2 (waddr_in_port_2),
        .waddr_in_port_3 (waddr_in_port_3)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stop_cnt = 0;
    int stray = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] addr;
        int         cyc;
    } wr_t;

    wr_t        q1[$], q2[$], q3[$];
    logic [7:0] pd [16];
    logic [3:0] exp_addr [1:3];

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (winc_port_1) q1.push_back('{wdata_port_1, waddr_in_port_1, cyc});
        else if (wdata_port_1 != 8'd0 || waddr_in_port_1 != 4'd0) stray++;
        if (winc_port_2) q2.push_back('{wdata_port_2, waddr_in_port_2, cyc});
        else if (wdata_port_2 != 8'd0 || waddr_in_port_2 != 4'd0) stray++;
        if (winc_port_3) q3.push_back('{wdata_port_3, waddr_in_port_3, cyc});
        else if (wdata_port_3 != 8'd0 || waddr_in_port_3 != 4'd0) stray++;
        if (stop_packet_send) stop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        #1;
        q1.delete();
        q2.delete();
        q3.delete();
        stop_cnt = 0;
        stray    = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk1);
        packet_valid_i = 1'b1;
        pdata          = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk1);
            packet_valid_i = 1'b0;
            pdata          = 8'd0;
        end
    endtask

    // Sends header and ndata data bytes (from pd[], or the byte index beyond
    // 16); the crc follows only when ndata == size. c0 = cycle stamp of the
    // negedge at which the crc was driven.
    task automatic send_pkt(input logic [7:0] src, input logic [7:0] dest,
                            input logic [7:0] size, input logic [7:0] crc,
                            input int ndata, output int c0);
        send_byte(src);
        send_byte(dest);
        send_byte(size);
        for (int i = 0; i < ndata; i++) begin
            if (i < 16) send_byte(pd[i]);
            else        send_byte(8'(i));
        end
        if (ndata == int'(size)) send_byte(crc);
        c0 = cyc;
    endtask

    // Port `port` must show exactly n writes pd[0..n-1] at the modelled
    // addresses, the i-th observed at cycle c0+2+i; other ports stay silent.
    task automatic expect_writes(input string tag, input int port, input int n, input int c0);
        wr_t q[$];
        case (port)
            1:       q = q1;
            2:       q = q2;
            default: q = q3;
        endcase
        check({tag, " count"}, q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < q.size()) begin
                check($sformatf("%s data%0d", tag, i), q[i].data, pd[i]);
                check($sformatf("%s addr%0d", tag, i), q[i].addr, exp_addr[port]);
                check($sformatf("%s cyc%0d", tag, i), q[i].cyc, c0 + 2 + i);
            end
            exp_addr[port] = exp_addr[port] + 4'd1;
        end
        if (port != 1) check({tag, " p1 idle"}, q1.size(), 0);
        if (port != 2) check({tag, " p2 idle"}, q2.size(), 0);
        if (port != 3) check({tag, " p3 idle"}, q3.size(), 0);
        check({tag, " stray"}, stray, 0);
    endtask

    task automatic expect_none(input string tag);
        check({tag, " writes"}, q1.size() + q2.size() + q3.size(), 0);
        check({tag, " stop"}, stop_cnt, 0);
        check({tag, " stray"}, stray, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " winc"}, {winc_port_1, winc_port_2, winc_port_3}, 0);
        check({tag, " wdata"}, {wdata_port_1, wdata_port_2, wdata_port_3}, 0);
        check({tag, " waddr"}, {waddr_in_port_1, waddr_in_port_2, waddr_in_port_3}, 0);
        check({tag, " stop"}, stop_packet_send, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [7:0] dests [4];
        int         ports [4];

        exp_addr[1] = 4'd0;
        exp_addr[2] = 4'd0;
        exp_addr[3] = 4'd0;

        // Reset state
        repeat (3) @(negedge clk1);
        check_outputs_zero("reset");
        rst = 1'b1;
        idle(2);

        // Port 1 routing: 171 ^ 172 = 7
        clear_mon();
        pd[0] = 8'd171; pd[1] = 8'd172;
        send_pkt(8'd1, 8'd6, 8'd2, 8'd7, 2, c0);
        idle(8);
        expect_writes("port1", 1, 2, c0);
        check("port1 stop", stop_cnt, 2);

        // Port 2 routing: 111^122^133^144 = 0
        clear_mon();
        pd[0] = 8'd111; pd[1] = 8'd122; pd[2] = 8'd133; pd[3] = 8'd144;
        send_pkt(8'd1, 8'd150, 8'd4, 8'd0, 4, c0);
        idle(10);
        expect_writes("port2", 2, 4, c0);
        check("port2 stop", stop_cnt, 4);

        // Source filter: src 123 has a nonzero upper nibble
        clear_mon();
        pd[0] = 8'd7; pd[1] = 8'd248;
        send_pkt(8'd123, 8'd221, 8'd2, 8'd255, 2, c0);
        idle(8);
`ifdef SRC_FILTER_EN
        expect_none("srcfilt");
`else
        expect_writes("srcfilt", 3, 2, c0);
        check("srcfilt stop", stop_cnt, 2);
`endif

        // Back-pressure: port 3 full for three FLUSH cycles
        clear_mon();
        pd[0] = 8'd24;
        send_pkt(8'd0, 8'd246, 8'd1, 8'd24, 1, c0);
        wfull_port_3 = 1'b1;
        idle(4);
        wfull_port_3 = 1'b0;
        idle(6);
        expect_writes("bkpr", 3, 1, c0 + 3);
        check("bkpr stop", stop_cnt, 4);

        // Bad crc, then an immediate good packet
        clear_mon();
        pd[0] = 8'd171; pd[1] = 8'd172;
        send_pkt(8'd1, 8'd6, 8'd2, 8'd27, 2, c0);
        send_pkt(8'd1, 8'd6, 8'd2, 8'd7, 2, c0);
        idle(8);
        expect_writes("badcrc", 1, 2, c0);
        check("badcrc stop", stop_cnt, 2);

        // Size 0, oversize discard (20 bytes + crc), then a good packet
        clear_mon();
        pd[0] = 8'h5A;
        send_pkt(8'd1, 8'd6, 8'd0, 8'd0, 0, c0);
        send_pkt(8'd1, 8'd6, 8'd20, 8'd99, 20, c0);
        send_pkt(8'd1, 8'd100, 8'd1, 8'h5A, 1, c0);
        idle(6);
        expect_writes("discard", 2, 1, c0);
        check("discard stop", stop_cnt, 1);

        // dest_id boundaries
        dests[0] = 8'd85;  ports[0] = 1;
        dests[1] = 8'd86;  ports[1] = 2;
        dests[2] = 8'd170; ports[2] = 2;
        dests[3] = 8'd171; ports[3] = 3;
        for (int k = 0; k < 4; k++) begin
            clear_mon();
            pd[0] = 8'(8'h10 + k);
            send_pkt(8'd2, dests[k], 8'd1, pd[0], 1, c0);
            idle(4);
            expect_writes($sformatf("dest%0d", dests[k]), ports[k], 1, c0);
        end

        // packet_valid_i drops mid-DATA
        clear_mon();
        pd[0] = 8'd1; pd[1] = 8'd2; pd[2] = 8'd3; pd[3] = 8'd4;
        send_pkt(8'd1, 8'd6, 8'd4, 8'd4, 2, c0);
        idle(8);
        expect_none("abort");

        // Reset in the middle of FLUSH (9^8^7^6 = 0)
        clear_mon();
        pd[0] = 8'd9; pd[1] = 8'd8; pd[2] = 8'd7; pd[3] = 8'd6;
        send_pkt(8'd1, 8'd6, 8'd4, 8'd0, 4, c0);
        idle(2);
        check("midflush stop", stop_packet_send, 1);
        #1 rst = 1'b0;
        #1 check_outputs_zero("midflush rst");
        @(negedge clk1);
        rst = 1'b1;
        exp_addr[1] = 4'd0;
        exp_addr[2] = 4'd0;
        exp_addr[3] = 4'd0;
        idle(1);
        clear_mon();
        pd[0] = 8'h33;
        send_pkt(8'd1, 8'd6, 8'd1, 8'h33, 1, c0);
        idle(4);
        expect_writes("postrst", 1, 1, c0);

        // 17 single-byte writes to port 1: address wraps 15 -> 0
        for (int k = 0; k < 17; k++) begin
            clear_mon();
            pd[0] = 8'(k + 1);
            send_pkt(8'd1, 8'd6, 8'd1, pd[0], 1, c0);
            idle(3);
            expect_writes($sformatf("wrap%0d", k), 1, 1, c0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_rx_router.md
# pkt_rx_router

Ingress packet receiver for the custom router. It deserialises a byte stream (src_id, dest_id, size, data…, crc) into a 16-byte buffer and validates it. A validated packet is routed by dest_id to one of three output-port FIFO write interfaces. Bad packets are discarded without any FIFO write.

## Interface
Parameters:
- none. Buffer depth is fixed at 16 bytes; FIFO address width is fixed at 4 bits.

Ports:
- clk1 input 1: sole clock; all state changes on the rising edge.
- rst input 1: asynchronous, active-low reset.
- packet_valid_i input 1: high while the sender drives a valid byte on pdata.
- pdata input 8: packet byte, one per clock.
- wfull_port_1/2/3 input 1 each: full flag of the corresponding port FIFO.
- stop_packet_send output 1: back-pressure to the sender.
- winc_port_1/2/3 output 1 each: one-cycle write strobe.
- wdata_port_1/2/3 output 8 each: write data.
- waddr_in_port_1/2/3 output 4 each: write address.

## Operation
- Packet format: src_id, dest_id, size, size data bytes, crc.
- crc is the XOR of the data bytes only; for size 0 the crc is 0.
- Port selection from dest_id: 0–85 selects port 1, 86–170 selects port 2, 171–255 selects port 3.
- Trusted means the crc matches and the source filter passes (see Configuration).
- States:
  - IDLE: if packet_valid_i, store pdata as src_id, go to DEST.
  - DEST: store dest_id and the selected port, go to SIZE.
  - SIZE: store size and clear the byte counter and running XOR. Size 0 goes to CRC, size 1–15 goes to DATA, size above 15 goes to DISCARD.
  - DATA: write the buffer at the counter, XOR into the running value, increment the counter. After the size-th byte, go to CRC.
  - DISCARD: count off size data bytes plus the crc without storing them, then go to IDLE.
  - CRC: compare pdata with the running XOR. Trusted with size ≥1 goes to FLUSH; otherwise go to IDLE.
  - FLUSH: each cycle the selected port's wfull is low, issue one write. Return to IDLE after the last byte.
- Per-port address counters are 4 bits. They persist across packets, increment after each write, and wrap from 15 to 0.
- Only the selected port's signals change. winc/wdata/waddr of the other ports stay at 0.
- In DEST, SIZE, DATA and CRC, packet_valid_i low aborts: go to IDLE, nothing is written, counters are unchanged.
- In FLUSH and DISCARD, packet_valid_i is ignored. In FLUSH, pdata is also ignored.

## Timing
- One byte is accepted per clock with packet_valid_i high. Back-to-back packets are allowed after a discard or a no-write packet.
- The crc byte is sampled at edge N. With no back-pressure, the write for data byte i is registered at edge N+1+i and winc is high for that one cycle.
- stop_packet_send is combinational: high exactly while the state is FLUSH. The sender must not start a packet while it is high.
- While wfull of the selected port is high: winc is low, the address holds, and the FLUSH byte index holds. Writing resumes the cycle after wfull falls.
- Reset values: state IDLE, all winc/wdata/waddr 0, stop_packet_send 0, address counters 0, buffer contents don't-care.
- rst low at any time, including mid-FLUSH, clears everything immediately.

## Configuration
- SRC_FILTER_EN defined: trusted additionally requires src_id[7:4] == 0.
- SRC_FILTER_EN undefined: any src_id passes, and only the crc check decides.

## Test plan
- Port 1 routing: src 1, dest 6, size 2, data 171,172, crc 7 -> port 1 writes 171@0 then 172@1 on consecutive cycles; stop high 2 cycles.
- Port 2 routing: src 1, dest 150, size 4, data 111,122,133,144, crc 0 -> port 2 writes addresses 0–3 in order; ports 1 and 3 stay idle.
- Source filter: src 123, dest 221, size 2, data 7,248, crc 255 -> with SRC_FILTER_EN, no winc and stop stays low; without it, port 3 writes 7@0 and 248@1.
- Back-pressure: src 0, dest 246, size 1, data 24, crc 24, with wfull_port_3=1 for 3 cycles after the crc edge -> stop high throughout, no winc while full, then 24 written @0 and stop drops.
- Bad crc: packet 1 with crc 27 -> no writes, back to IDLE, and an immediate next packet is accepted.
- Abort/reset/wrap:
  - packet_valid_i falls mid-DATA -> no writes.
  - rst low mid-FLUSH -> all outputs 0 and address counters 0.
  - 17 single-byte writes to port 1 -> address wraps from 15 to 0.
